// File: rtl/mux2_rr_arbiter_pkg.sv
// rtl/mux2_rr_arbiter_pkg.sv - shared state encodings and counter-width helper for the two-port arbiter
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux2_tg.sv
// rtl/mux2_tg.sv - 1-bit transmission-gate style 2:1 mux cell
module mux2_tg (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - WIDTH-wide 2:1 data mux built from per-bit mux cells
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_tg u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .y   (y[i])
        );
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin burst arbiter owning the select of a shared 2:1 stream mux
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       gnt,
    output logic             burst_cut
);

    localparam int             CNT_W   = clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BEATS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_grant;
    logic [WIDTH-1:0] mux_y;

    logic granted, on_p1, src_valid, src_last, at_limit;
    logic acc, rel, cut, req0, req1, prev_port, arb_en;

    mux2_w #(.WIDTH(WIDTH)) u_mux (
        .a   (in0_data),
        .b   (in1_data),
        .sel (sel),
        .y   (mux_y)
    );

    always_comb begin
        granted   = (state != ST_IDLE);
        on_p1     = (state == ST_G1);
        src_valid = on_p1 ? in1_valid : in0_valid;
        src_last  = on_p1 ? in1_last : in0_last;
        at_limit  = (beat_cnt == CNT_LIM);

        out_valid = granted & src_valid & ~rst;
        out_data  = granted ? mux_y : '0;
        out_last  = granted & (src_last | at_limit);
        in0_ready = (state == ST_G0) & out_ready & ~rst;
        in1_ready = (state == ST_G1) & out_ready & ~rst;

        acc = out_valid & out_ready;
        rel = acc & out_last;
        cut = rel & ~src_last;
    end

    // On a natural end of burst the releasing port's valid belongs to the beat
    // being consumed, so it is not a new request; after a cut it still has data.
    always_comb begin
        req0      = in0_valid & ~(rel & ~cut & (state == ST_G0));
        req1      = in1_valid & ~(rel & ~cut & (state == ST_G1));
        prev_port = rel ? on_p1 : last_grant;
        arb_en    = (state == ST_IDLE) | rel;
        state_nxt = state;
        if (arb_en) begin
            if (req0 & req1) begin
                state_nxt = prev_port ? ST_G0 : ST_G1;
            end else if (req0) begin
                state_nxt = ST_G0;
            end else if (req1) begin
                state_nxt = ST_G1;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= 2'b00;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            burst_cut  <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= {state_nxt == ST_G1, state_nxt == ST_G0};
            burst_cut <= cut;
            // sel keeps its value through IDLE so the shared mux only toggles on real handovers
            if (state_nxt != ST_IDLE) begin
                sel <= (state_nxt == ST_G1);
            end
            if (rel) begin
                last_grant <= on_p1;
                beat_cnt   <= '0;
            end else if (acc) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for the two-port round-robin burst arbiter
module tb_mux2_rr_arbiter;

    localparam int W    = 8;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_valid, in0_last, in0_ready;
    logic         in1_valid, in1_last, in1_ready;
    logic [W-1:0] in0_data, in1_data, out_data;
    logic         out_valid, out_last, out_ready;
    logic         sel, burst_cut;
    logic [1:0]   gnt;

    beat_t src0[$], src1[$], exp0[$], exp1[$];
    int    order[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    mcnt = 0;
    int    cut_seen = 0;
    bit    exp_cut = 1'b0;
    bit    en0 = 1'b0;
    bit    en1 = 1'b0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .burst_cut (burst_cut)
    );

    // Producers present queue heads after each edge; the monitor samples on the falling edge.
    initial begin
        int    p;
        beat_t e;
        bit    want_last;
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            in0_valid = en0 && (src0.size() > 0);
            in0_data  = in0_valid ? src0[0].data : '0;
            in0_last  = in0_valid ? src0[0].last : 1'b0;
            in1_valid = en1 && (src1.size() > 0);
            in1_data  = in1_valid ? src1[0].data : '0;
            in1_last  = in1_valid ? src1[0].last : 1'b0;
            @(negedge clk);
            if (rst) begin
                mcnt    = 0;
                exp_cut = 1'b0;
            end else begin
                total_cnt++;
                if (burst_cut !== exp_cut) $display("FAIL burst_cut: got %b want %b at %0t", burst_cut, exp_cut, $time);
                else pass_cnt++;
                if (burst_cut === 1'b1) cut_seen++;
                exp_cut = 1'b0;
                if (in0_valid && in0_ready) void'(src0.pop_front());
                if (in1_valid && in1_ready) void'(src1.pop_front());
                if (out_valid && out_ready) begin
                    p = gnt[1] ? 1 : 0;
                    total_cnt++;
                    if ((gnt !== 2'b01 && gnt !== 2'b10) || sel !== p[0])
                        $display("FAIL beat_grant: gnt %b sel %b", gnt, sel);
                    else pass_cnt++;
                    total_cnt++;
                    if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
                        $display("FAIL beat_unexpected: port %0d data %h with empty scoreboard", p, out_data);
                    end else begin
                        e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
                        want_last = e.last || (mcnt == MAXB - 1);
                        if (out_data !== e.data || out_last !== want_last)
                            $display("FAIL beat_data: port %0d got %h/%b want %h/%b", p, out_data, out_last, e.data, want_last);
                        else pass_cnt++;
                        if (want_last) begin
                            order.push_back(p);
                            exp_cut = !e.last;
                            mcnt = 0;
                        end else begin
                            mcnt++;
                        end
                    end
                end
            end
        end
    end

    task automatic push_beat(input int port, input logic [W-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        if (port == 0) begin src0.push_back(b); exp0.push_back(b); end
        else begin src1.push_back(b); exp1.push_back(b); end
    endtask

    task automatic clear_all();
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete(); order.delete();
        cut_seen = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; out_ready = 1'b1;
        clear_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        total_cnt++;
        if (exp0.size() != 0 || exp1.size() != 0)
            $display("FAIL drain_timeout: %0d/%0d beats left want 0/0", exp0.size(), exp1.size());
        else pass_cnt++;
    endtask

    task automatic wait_size(input int port, input int size, input int budget);
        int n;
        n = 0;
        while (((port == 0) ? exp0.size() : exp1.size()) != size && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        total_cnt++;
        if (((port == 0) ? exp0.size() : exp1.size()) != size)
            $display("FAIL wait_timeout: port %0d scoreboard never reached %0d", port, size);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total_cnt++; if (gnt !== 2'b00) $display("FAIL rst_gnt: got %b want 00", gnt); else pass_cnt++;
        total_cnt++; if (sel !== 1'b0) $display("FAIL rst_sel: got %b want 0", sel); else pass_cnt++;
        total_cnt++; if (burst_cut !== 1'b0) $display("FAIL rst_cut: got %b want 0", burst_cut); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0 || out_last !== 1'b0) $display("FAIL rst_out: got %b/%b want 0/0", out_valid, out_last); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL rst_data: got %h want 00", out_data); else pass_cnt++;
        total_cnt++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) $display("FAIL rst_ready: got %b%b want 00", in0_ready, in1_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        do_reset();
        @(posedge clk); #1;
        push_beat(0, 8'h11, 1'b0); push_beat(0, 8'h22, 1'b0); push_beat(0, 8'h33, 1'b1);
        en0 = 1'b1;
        @(negedge clk); #1;
        total_cnt++; if (gnt !== 2'b00) $display("FAIL single_pre_gnt: got %b want 00", gnt); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (gnt !== 2'b01 || sel !== 1'b0) $display("FAIL single_gnt: got %b sel %b want 01 sel 0", gnt, sel); else pass_cnt++;
        wait_drain(20);
        @(negedge clk); #1;
        total_cnt++; if (gnt !== 2'b00 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL single_idle: gnt %b valid %b data %h want 00/0/00", gnt, out_valid, out_data);
        else pass_cnt++;
        total_cnt++; if (order.size() != 1 || order[0] != 0) $display("FAIL single_order: %0d bursts want 1 from port 0", order.size()); else pass_cnt++;
    endtask

    task automatic test_alternate();
        int want[4] = '{0, 1, 0, 1};
        int bubbles, n;
        bit started;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            push_beat(0, 8'hA0 + 8'(i), (i % 2) == 1);
            push_beat(1, 8'hB0 + 8'(i), (i % 2) == 1);
        end
        en0 = 1'b1; en1 = 1'b1;
        bubbles = 0; started = 1'b0; n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (started && !out_valid && (exp0.size() != 0 || exp1.size() != 0)) bubbles++;
            if (out_valid) started = 1'b1;
        end
        total_cnt++; if (n >= 40) $display("FAIL alt_timeout: %0d beats left want 0", exp0.size() + exp1.size()); else pass_cnt++;
        total_cnt++; if (bubbles != 0) $display("FAIL alt_bubble: got %0d idle cycles want 0", bubbles); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= order.size() || order[i] != want[i]) $display("FAIL alt_order%0d: got %0d want %0d", i, (i < order.size()) ? order[i] : -1, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_beat_limit();
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) push_beat(0, 8'h40 + 8'(i), 1'b0);
        en0 = 1'b1;
        @(posedge clk); #1;
        push_beat(1, 8'h50, 1'b0); push_beat(1, 8'h51, 1'b1);
        en1 = 1'b1;
        wait_drain(60);
        @(negedge clk); #1;
        total_cnt++; if (gnt !== 2'b01) $display("FAIL limit_hold: got %b want 01", gnt); else pass_cnt++;
        total_cnt++; if (cut_seen != 2) $display("FAIL limit_cuts: got %0d want 2", cut_seen); else pass_cnt++;
        total_cnt++; if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0)
            $display("FAIL limit_order: got %0d releases want 0,1,0", order.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(posedge clk); #1;
        push_beat(0, 8'hC0, 1'b0); push_beat(0, 8'hC1, 1'b0); push_beat(0, 8'hC2, 1'b1);
        en0 = 1'b1;
        wait_size(0, 2, 20);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            total_cnt++; if (in0_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", in0_ready); else pass_cnt++;
            total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'hC1 || out_last !== 1'b0)
                $display("FAIL bp_hold: got %b/%h/%b want 1/c1/0", out_valid, out_data, out_last);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(20);
        total_cnt++; if (order.size() != 1) $display("FAIL bp_bursts: got %0d want 1", order.size()); else pass_cnt++;
    endtask

    task automatic test_valid_gap();
        do_reset();
        @(posedge clk); #1;
        push_beat(0, 8'hD0, 1'b0); push_beat(0, 8'hD1, 1'b0); push_beat(0, 8'hD2, 1'b1);
        en0 = 1'b1;
        wait_size(0, 2, 20);
        @(posedge clk); #1;
        en0 = 1'b0;
        push_beat(1, 8'hE0, 1'b0); push_beat(1, 8'hE1, 1'b1);
        en1 = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            total_cnt++; if (gnt !== 2'b01 || in1_ready !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL gap_hold: gnt %b in1_ready %b valid %b want 01/0/0", gnt, in1_ready, out_valid);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        en0 = 1'b1;
        wait_drain(30);
        total_cnt++; if (order.size() != 2 || order[0] != 0 || order[1] != 1)
            $display("FAIL gap_order: got %0d releases want 0,1", order.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_beat(1, 8'hF0 + 8'(i), i == 3);
        en1 = 1'b1;
        wait_size(1, 3, 20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        total_cnt++; if (in1_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rstmid_accept: in1_ready %b valid %b want 0/0", in1_ready, out_valid);
        else pass_cnt++;
        total_cnt++; if (exp1.size() != 3) $display("FAIL rstmid_beats: got %0d left want 3", exp1.size()); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_all();
        push_beat(0, 8'h61, 1'b1);
        push_beat(1, 8'h71, 1'b1);
        en0 = 1'b1; en1 = 1'b1;
        @(negedge clk); #1;
        total_cnt++; if (gnt !== 2'b00 || sel !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rstmid_state: gnt %b sel %b valid %b want 00/0/0", gnt, sel, out_valid);
        else pass_cnt++;
        wait_drain(20);
        total_cnt++; if (order.size() != 2 || order[0] != 0 || order[1] != 1)
            $display("FAIL rstmid_tie: got %0d releases want 0,1", order.size());
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_single_burst();
        test_alternate();
        test_beat_limit();
        test_backpressure();
        test_valid_gap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 data mux between two streaming requesters and drives the mux select.
- Each requester presents valid/data/last bursts. The arbiter grants one port at a time and holds the grant for the whole burst.
- It forwards the granted port to a single valid/ready consumer.
- A beat limit forces release so one port cannot starve the other.
- Sits between two producer blocks and the shared mux datapath, and owns its select line.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- MAX_BEATS, 16, maximum beats per grant before forced release; legal range 2..256.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in0_valid  input  1  port 0 has a beat.
- in0_data  input  WIDTH  port 0 beat data.
- in0_last  input  1  port 0 beat is the end of its burst.
- in0_ready  output  1  port 0 beat accepted this cycle when high together with in0_valid.
- in1_valid, in1_data, in1_last, in1_ready  same as port 0, for port 1.
- out_valid  output  1  forwarded beat valid.
- out_data  output  WIDTH  forwarded beat data.
- out_last  output  1  forwarded last flag; also high on a forced-release beat.
- out_ready  input  1  consumer accepts a beat.
- sel  output  1  mux select: 0 = port 0, 1 = port 1.
- gnt  output  2  one-hot grant; 00 when idle.
- burst_cut  output  1  one-cycle pulse when a grant is released by the beat limit rather than by last.

Behaviour:
- Reset values: state IDLE, gnt=00, sel=0, last_grant=1 (port 0 wins the first tie), beat_cnt=0, burst_cut=0.
- Reset output values: out_valid=0, out_data=0, out_last=0, in0_ready=0, in1_ready=0.
- Reset taken mid-burst drops the grant immediately on the next edge; no beat is accepted in the reset cycle.
- States: IDLE, G0, G1. gnt, sel, state and beat_cnt are registered. Handshake paths are combinational from state.
- In G0:
  - out_valid=in0_valid, out_data=in0_data, in0_ready=out_ready, in1_ready=0.
  - out_last = in0_last OR (beat_cnt==MAX_BEATS-1).
- In G1: symmetric with port 1.
- In IDLE: out_valid=0, out_data=0, both readys 0.
- Beat accepted (acc): out_valid & out_ready in G0/G1. Each acc increments beat_cnt.
- Release: acc with out_last=1. On release, last_grant <= current port and beat_cnt <= 0.
- burst_cut <= 1 for the cycle after a release where the source in*_last was 0.
- Arbitration runs in IDLE and in a release cycle. Requests are in0_valid and in1_valid.
  - Only one requesting: grant it.
  - Both requesting: grant the port != last_grant.
  - Neither requesting: go to IDLE.
- Latency: valid to grant is 1 cycle. Back-to-back handover on release has no idle bubble; for example G0 -> G1 directly when in1_valid=1.
- A granted port may deassert valid mid-burst. The grant is held with no release and no timeout until last or the beat limit.
- The same port can be re-granted immediately after release only if the other port is not requesting.
- sel changes only on grant changes. sel holds its last value while IDLE, so the mux select toggles no more than necessary.
- beat_cnt width is clog2(MAX_BEATS). It never wraps because release at MAX_BEATS-1 clears it.

Decomposition:
- Shared package/header: state encodings ST_IDLE, ST_G0, ST_G1, and the clog2 helper for the counter width.
- One natural sub-module: mux2_w, a WIDTH-wide 2:1 mux driven by sel. It reuses the team's existing 1-bit transmission-gate mux per bit via generate.
- Arbitration, counter and handshake logic stay in the top module.

Test Plan:
- Reset then in0_valid=1 with a 3-beat burst (last on beat 3), out_ready=1 → gnt=01 one cycle later, sel=0, three beats on out_data, out_last on beat 3, then IDLE with gnt=00.
- Both ports valid from reset with 2-beat bursts each → order is port 0, port 1, port 0, port 1, with a direct G0→G1 handover and no bubble cycle.
- MAX_BEATS=4, port 0 streams 10 beats with no last while port 1 waits → release after beat 4 with out_last=1 and burst_cut pulsing once; G1 follows.
- out_ready=0 for 3 cycles mid-burst → in0_ready=0, out_data stable, beat_cnt unchanged, no beat lost or duplicated.
- Granted port drops valid for 5 cycles mid-burst while the other port is valid → grant held, in1_ready=0 throughout, and the burst resumes on the same port.
- rst asserted during beat 2 of a G1 burst → next cycle gnt=00, out_valid=0, sel=0; a following tie goes to port 0.
